// File: rtl/arch_map_retire.sv
// Committed (architectural) map table plus a 2-entry release queue.
// Each accepted retire installs T_new and queues the displaced mapping
// so the Free_List can reclaim it.
module arch_map_retire #(
    parameter int NUM_ARCH_REG = 32,
    parameter int NUM_PHYS_REG = 64,
    localparam int PR_W = $clog2(NUM_PHYS_REG),
    localparam int AR_W = $clog2(NUM_ARCH_REG)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         retire_en,
    input  logic [AR_W-1:0]              retire_arch_reg,
    input  logic [PR_W-1:0]              retire_T_new,
    input  logic                         fl_ready,
    output logic                         retire_stall,
    output logic [PR_W-1:0]              T_old,
    output logic                         T_old_valid,
    output logic [NUM_ARCH_REG*PR_W-1:0] arch_map_out,
    output logic [1:0]                   q_count
);

    logic [NUM_ARCH_REG-1:0][PR_W-1:0] map_q;
    logic [1:0][PR_W-1:0]              q_mem;
    logic                              rd_ptr;
    logic                              wr_ptr;
    logic [1:0]                        count;
    logic                              push;
    logic                              pop;

    // Stall comes from the registered count only: a pop in the same cycle
    // does not free a slot for the retire.
    assign retire_stall = (count == 2'd2);
    assign T_old_valid  = (count != 2'd0);
    assign T_old        = T_old_valid ? q_mem[rd_ptr] : '0;
    assign q_count      = count;
    assign arch_map_out = map_q;

    assign push = retire_en && !retire_stall;
    assign pop  = T_old_valid && fl_ready;

    // Committed map: identity on reset, otherwise install T_new on accepted retire.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ARCH_REG; i++)
                map_q[i] <= PR_W'(i);
        end else if (push) begin
            map_q[retire_arch_reg] <= retire_T_new;
        end
    end

    // Release FIFO: enqueue the displaced mapping (pre-write value), drain on fl_ready.
    always_ff @(posedge clock) begin
        if (!reset) begin
            q_mem  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= map_q[retire_arch_reg];
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_arch_map_retire.sv
// Bench for arch_map_retire: directed scenarios with literal expectations,
// a map/queue reference model checked every cycle, and a random phase
// whose release stream is compared in order against the model.
module tb_arch_map_retire;

    localparam int NA   = 32;
    localparam int NP   = 64;
    localparam int PR_W = 6;
    localparam int AR_W = 5;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 retire_en = 1'b0;
    logic [AR_W-1:0]      retire_arch_reg = '0;
    logic [PR_W-1:0]      retire_T_new = '0;
    logic                 fl_ready = 1'b0;
    logic                 retire_stall;
    logic [PR_W-1:0]      T_old;
    logic                 T_old_valid;
    logic [NA*PR_W-1:0]   arch_map_out;
    logic [1:0]           q_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    int  mmap [NA];
    int  mq[$];
    int  mrel[$];
    int  drel[$];
    bit  armed = 1'b0;

    arch_map_retire #(.NUM_ARCH_REG(NA), .NUM_PHYS_REG(NP)) dut (
        .clock           (clock),
        .reset           (reset),
        .retire_en       (retire_en),
        .retire_arch_reg (retire_arch_reg),
        .retire_T_new    (retire_T_new),
        .fl_ready        (fl_ready),
        .retire_stall    (retire_stall),
        .T_old           (T_old),
        .T_old_valid     (T_old_valid),
        .arch_map_out    (arch_map_out),
        .q_count         (q_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int map_ent(input int i);
        return int'(arch_map_out[i*PR_W +: PR_W]);
    endfunction

    // Model: applies the retirement rules at each edge from pre-edge state.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NA; i++) mmap[i] = i;
            mq.delete();
            armed = 1'b1;
        end else if (armed) begin
            bit acc;
            bit pp;
            acc = retire_en && (mq.size() < 2);
            pp  = fl_ready && (mq.size() > 0);
            if (pp) mrel.push_back(mq.pop_front());
            if (acc) begin
                mq.push_back(mmap[retire_arch_reg]);
                mmap[retire_arch_reg] = int'(retire_T_new);
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clock) begin
        if (armed) begin
            for (int i = 0; i < NA; i++)
                chk($sformatf("map[%0d]", i), map_ent(i), mmap[i]);
            chk("q_count", int'(q_count), mq.size());
            chk("T_old_valid", int'(T_old_valid), int'(mq.size() > 0));
            chk("retire_stall", int'(retire_stall), int'(mq.size() == 2));
            if (mq.size() > 0) chk("T_old", int'(T_old), mq[0]);
            // inputs are already set for the coming edge: record a DUT release
            if (reset && T_old_valid && fl_ready) drel.push_back(int'(T_old));
        end
    end

    task automatic step(input bit rn, input bit re, input int ar, input int tn, input bit fr);
        reset           = rn;
        retire_en       = re;
        retire_arch_reg = AR_W'(ar);
        retire_T_new    = PR_W'(tn);
        fl_ready        = fr;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // 1: reset
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < NA; i += 7) chk($sformatf("rst map[%0d]", i), map_ent(i), i);
        chk("rst map[31]", map_ent(31), 31);
        chk("rst valid", int'(T_old_valid), 0);
        chk("rst q_count", int'(q_count), 0);
        chk("rst stall", int'(retire_stall), 0);
        chk("rst T_old", int'(T_old), 0);

        // 2: single retire, immediate drain
        step(1, 1, 3, 40, 1);
        chk("t2 T_old", int'(T_old), 3);
        chk("t2 valid", int'(T_old_valid), 1);
        chk("t2 map3", map_ent(3), 40);
        step(1, 0, 0, 0, 1);
        chk("t2 valid drained", int'(T_old_valid), 0);

        // 3: fill queue, stall, ignored retire, drain in order
        step(1, 1, 5, 41, 0);
        chk("t3 q1", int'(q_count), 1);
        step(1, 1, 5, 42, 0);
        chk("t3 q2", int'(q_count), 2);
        chk("t3 stall", int'(retire_stall), 1);
        chk("t3 map5", map_ent(5), 42);
        chk("t3 head", int'(T_old), 5);
        step(1, 1, 6, 60, 0);
        chk("t3 map6 kept", map_ent(6), 6);
        chk("t3 q still 2", int'(q_count), 2);
        step(1, 0, 0, 0, 1);
        chk("t3 second", int'(T_old), 41);
        chk("t3 q after pop", int'(q_count), 1);
        step(1, 0, 0, 0, 1);
        chk("t3 empty", int'(T_old_valid), 0);

        // 4: push and pop together at q_count==1
        step(1, 1, 8, 51, 0);
        chk("t4 head8", int'(T_old), 8);
        step(1, 1, 7, 50, 1);
        chk("t4 q stays 1", int'(q_count), 1);
        chk("t4 T_old", int'(T_old), 7);
        chk("t4 map7", map_ent(7), 50);
        step(1, 0, 0, 0, 1);

        // 5: reset dominates a full queue and a pending retire
        step(1, 1, 9, 52, 0);
        step(1, 1, 10, 53, 0);
        chk("t5 full", int'(q_count), 2);
        step(0, 1, 11, 54, 1);
        chk("t5 map3", map_ent(3), 3);
        chk("t5 map9", map_ent(9), 9);
        chk("t5 map11", map_ent(11), 11);
        chk("t5 q", int'(q_count), 0);
        chk("t5 valid", int'(T_old_valid), 0);
        mrel.delete();
        drel.delete();

        // 6: random retires against the model
        for (int n = 0; n < 400; n++)
            step(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, NA-1)),
                 int'($urandom_range(0, NP-1)), 1'($urandom_range(0, 2) != 0));
        for (int n = 0; n < 4; n++) step(1, 0, 0, 0, 1);
        chk("t6 release count", drel.size(), mrel.size());
        chk("t6 drained", int'(T_old_valid), 0);
        for (int i = 0; i < mrel.size() && i < drel.size(); i++)
            chk($sformatf("t6 rel[%0d]", i), drel[i], mrel[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
